uart_rx_ctrl: RTL and testbench

UART receive controller clocked once per bit by Baud_Clk. It detects the start bit on the serial line and drives Shift1 of the adjacent 32-bit right-shifting SIPO for exactly DATA_BITS bit times. It then checks the optional parity bit and the stop bit, and presents the right-aligned received word with a one-cycle valid pulse and error flags to the host side.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_ctrl_if.sv | 17 +
 rtl/uart_rx_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state encoding for the UART receive controller.
//   state_e       : IDLE / DATA / PARITY / STOP / RECOVER, 3-bit encoding
//   SIPO_W        : width of the adjacent right-shifting SIPO
//   MAX_DATA_BITS : largest legal DATA_BITS
//   CNT_W         : bit-counter width, big enough to hold MAX_DATA_BITS without wrapping
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA    = 3'd1,
    PARITY  = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } state_e;
  localparam int SIPO_W        = 32;
  localparam int MAX_DATA_BITS = 32;
  localparam int CNT_W         = $clog2(MAX_DATA_BITS + 1);
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: host-side result bundle of the UART receive controller.
//   Rx_word    : received data, right-aligned, upper bits zero
//   Rx_valid   : one-cycle pulse per completed frame
//   Parity_err : parity mismatch, meaningful only with Rx_valid
//   Frame_err  : stop bit sampled low, meaningful only with Rx_valid
//   Busy       : receiver is not idle
//   master = receiver side (drives), slave = host side (observes)
interface uart_rx_ctrl_if;
  import uart_pkg::*;
  logic [SIPO_W-1:0] Rx_word;
  logic              Rx_valid;
  logic              Parity_err;
  logic              Frame_err;
  logic              Busy;
  modport master (output Rx_word, Rx_valid, Parity_err, Frame_err, Busy);
  modport slave  (input  Rx_word, Rx_valid, Parity_err, Frame_err, Busy);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: one-sample-per-bit UART receive controller driving an external 32-bit SIPO.
//   Baud_Clk : bit-rate clock, one rising edge per bit time
//   Reset    : asynchronous, active-low
//   Rx_In    : serial line, idle high, LSB first
//   Rx_data  : SIPO parallel output, newest bit at [31]
//   Shift1   : SIPO shift enable, high while in DATA
//   host     : uart_rx_ctrl_if.master (Rx_word, Rx_valid, Parity_err, Frame_err, Busy)
// Optional feature: define UART_RX_PARITY_EN to add the parity bit (PARITY_ODD selects odd parity).
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic              Baud_Clk,
  input  logic              Reset,
  input  logic              Rx_In,
  input  logic [SIPO_W-1:0] Rx_data,
  output logic              Shift1,
  uart_rx_ctrl_if.master    host
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);
  localparam int SHAMT = SIPO_W - DATA_BITS;
`ifdef UART_RX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIPO_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic              acc_q, acc_d;
  logic              pend_q, pend_d;
  logic              perr_q, perr_d;
`endif
  always_ff @(posedge Baud_Clk or negedge Reset)
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      acc_q   <= 1'b0;
      pend_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      perr_q  <= perr_d;
`endif
    end
  // Flags default to 0 every cycle so they are only ever high alongside Rx_valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    acc_d   = acc_q;
    pend_d  = pend_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: if (!Rx_In) begin
        state_d = DATA;
        cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
        acc_d   = 1'b0;
`endif
      end
      DATA: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
        acc_d   = acc_q ^ Rx_In;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        pend_d  = acc_q ^ Rx_In ^ PARITY_ODD;
        state_d = STOP;
      end
`endif
      STOP: begin
        // SIPO shifts right, so the frame's DATA_BITS bits sit at the top.
        word_d  = Rx_data >> SHAMT;
        valid_d = 1'b1;
        ferr_d  = ~Rx_In;
        state_d = Rx_In ? IDLE : RECOVER;
`ifdef UART_RX_PARITY_EN
        perr_d  = pend_q;
`endif
      end
      RECOVER: state_d = Rx_In ? IDLE : RECOVER;
      default: state_d = IDLE;
    endcase
  end
  assign Shift1          = state_q == DATA;
  assign host.Busy       = state_q != IDLE;
  assign host.Rx_word    = word_q;
  assign host.Rx_valid   = valid_q;
  assign host.Frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign host.Parity_err = perr_q;
`else
  assign host.Parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with an 8-bit and a 32-bit instance.
module tb_uart_rx_ctrl;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam logic PODD = 1'b0;
  typedef struct {
    logic [31:0] w;
    logic        pe;
    logic        fe;
    int          cyc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx8 = 1'b1;
  logic        rx32 = 1'b1;
  logic [31:0] sipo8 = 32'hFFFF_FFFF;
  logic [31:0] sipo32 = 32'h1234_5678;
  logic        sh8, sh32;
  int          cyc = 0;
  int          sh32_cnt = 0;
  int          checks = 0;
  int          fails = 0;
  exp_t        q8[$];
  exp_t        q32[$];
  exp_t        e8, e32;
  uart_rx_ctrl_if h8();
  uart_rx_ctrl_if h32();
  uart_rx_ctrl #(.DATA_BITS(8)) u8 (
    .Baud_Clk(clk), .Reset(rst_n), .Rx_In(rx8), .Rx_data(sipo8), .Shift1(sh8), .host(h8)
  );
  uart_rx_ctrl #(.DATA_BITS(32)) u32 (
    .Baud_Clk(clk), .Reset(rst_n), .Rx_In(rx32), .Rx_data(sipo32), .Shift1(sh32), .host(h32)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (sh8) sipo8 <= {rx8, sipo8[31:1]};
  always @(posedge clk) if (sh32) sipo32 <= {rx32, sipo32[31:1]};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (sh32) sh32_cnt <= sh32_cnt + 1;
    if (h8.Rx_valid) begin
      if (q8.size() == 0) chk("spurious8", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("word8", h8.Rx_word, e8.w);
        chk("perr8", h8.Parity_err, e8.pe);
        chk("ferr8", h8.Frame_err, e8.fe);
        chk("time8", cyc, e8.cyc);
      end
    end else chk("flags8_idle", {h8.Parity_err, h8.Frame_err}, 0);
    if (h32.Rx_valid) begin
      if (q32.size() == 0) chk("spurious32", 1, 0);
      else begin
        e32 = q32.pop_front();
        chk("word32", h32.Rx_word, e32.w);
        chk("perr32", h32.Parity_err, e32.pe);
        chk("ferr32", h32.Frame_err, e32.fe);
        chk("time32", cyc, e32.cyc);
      end
    end else chk("flags32_idle", {h32.Parity_err, h32.Frame_err}, 0);
  end
  task automatic drive(input bit w, input logic v);
    if (w) rx32 = v;
    else rx8 = v;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx8 = 1'b1;
      rx32 = 1'b1;
    end
  endtask
  // Drives start, data, optional parity and stop; the stop level is left on the line.
  task automatic send(input bit w, input logic [31:0] d, input bit flip, input logic stop);
    int db;
    logic [31:0] dm;
    exp_t e;
    db = w ? 32 : 8;
    dm = w ? d : (d & 32'hFF);
    @(negedge clk);
    e.w = dm;
    e.pe = flip && (P == 1);
    e.fe = ~stop;
    e.cyc = cyc + 1 + db + 1 + P;
    if (w) q32.push_back(e);
    else q8.push_back(e);
    drive(w, 1'b0);
    for (int i = 0; i < db; i++) begin
      @(negedge clk);
      drive(w, dm[i]);
    end
    if (P == 1) begin
      @(negedge clk);
      drive(w, ^dm ^ PODD ^ flip);
    end
    @(negedge clk);
    drive(w, stop);
  endtask
  task automatic chk_zero8(input string tag);
    chk({tag, "_shift"}, sh8, 0);
    chk({tag, "_word"}, h8.Rx_word, 0);
    chk({tag, "_valid"}, h8.Rx_valid, 0);
    chk({tag, "_perr"}, h8.Parity_err, 0);
    chk({tag, "_ferr"}, h8.Frame_err, 0);
    chk({tag, "_busy"}, h8.Busy, 0);
  endtask
  initial begin
    int base;
    logic [7:0] d;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero8("reset8");
    chk("reset32_busy", h32.Busy, 0);
    chk("reset32_word", h32.Rx_word, 0);
    rst_n = 1'b1;
    idle(2);
    send(0, 32'hA5, 0, 1'b1);
    idle(3);
    send(0, 32'hA5, 1, 1'b1);
    idle(3);
    send(0, 32'h3C, 0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      rx8 = 1'b0;
      chk("recover_busy", h8.Busy, 1);
      chk("recover_shift", sh8, 0);
    end
    @(negedge clk);
    rx8 = 1'b1;
    @(negedge clk);
    chk("recover_exit_busy", h8.Busy, 0);
    idle(2);
    send(0, 32'h01, 0, 1'b1);
    send(0, 32'hFF, 0, 1'b1);
    idle(3);
    d = 8'h5A;
    @(negedge clk);
    rx8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx8 = d[i];
    end
    #2 rst_n = 1'b0;
    #1 chk_zero8("midreset");
    @(negedge clk);
    rx8 = 1'b1;
    rst_n = 1'b1;
    idle(2);
    send(0, 32'h55, 0, 1'b1);
    idle(3);
    base = sh32_cnt;
    send(1, 32'hDEAD_BEEF, 0, 1'b1);
    idle(3);
    chk("shift32_cycles", sh32_cnt - base, 32);
    chk("pending8", q8.size(), 0);
    chk("pending32", q32.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
